// File: rtl/io_port_sched_pkg.sv
// Shared constants, types and helpers for the I/O port scheduler.
package io_port_sched_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // One bit of headroom so a saturation check can see the carry
  typedef logic [CNT_W:0] cnt_sum_t;

  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/io_port_sched_slot.sv
// io_slot: single-entry buffer with a full flag; a write wins over a same-cycle read.
module io_slot
  import io_port_sched_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // next-state: write refills (even when draining), read empties
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_i) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end else if (rd_i) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/io_port_sched.sv
// io_port_sched: per-channel buffers between external streams and the processor I/O ports.
// Optional macro IO_SCHED_STATS_EN enables the saturating error-event counter on err_cnt.
module io_port_sched
  import io_port_sched_pkg::*;
#(
  parameter int NBIN   = 19,
  parameter int NBOUT  = 28,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUIOIN*NBIN-1:0]   src_data,
  input  logic [NUIOIN-1:0]        src_valid,
  output logic [NUIOIN-1:0]        src_ready,
  output logic [NBIN-1:0]          io_in,
  input  logic [NUIOIN-1:0]        req_in,
  input  logic [NBOUT-1:0]         io_out,
  input  logic [NUIOOU-1:0]        out_en,
  output logic [NUIOOU*NBOUT-1:0]  dst_data,
  output logic [NUIOOU-1:0]        dst_valid,
  input  logic [NUIOOU-1:0]        dst_ready,
  input  logic                     err_clr,
  output logic [NUIOIN-1:0]        err_und,
  output logic [NUIOOU-1:0]        err_ovf,
  output logic                     err_proto,
  output logic [CNT_W-1:0]         err_cnt
);

  logic              req_ok_s, out_ok_s, proto_ev_s;
  logic [NUIOIN-1:0] in_full_s, take_s, accept_s, und_ev_s;
  logic [NBIN-1:0]   in_data_s [NUIOIN];
  logic [NUIOOU-1:0] wr_s, drain_s, ovf_ev_s;

  assign req_ok_s   = onehot0(32'(req_in));
  assign out_ok_s   = onehot0(32'(out_en));
  assign proto_ev_s = ~req_ok_s | ~out_ok_s;

  // src_ready depends only on local slot state and req_in, never on the output side
  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    assign take_s[k]    = req_ok_s & req_in[k] & in_full_s[k];
    assign und_ev_s[k]  = req_ok_s & req_in[k] & ~in_full_s[k];
    assign src_ready[k] = rst & (~in_full_s[k] | take_s[k]);
    assign accept_s[k]  = src_valid[k] & src_ready[k];

    io_slot #(.W(NBIN)) u_in_slot (
      .clk       (clk),
      .rst_n     (rst),
      .wr_i      (accept_s[k]),
      .wr_data_i (src_data[k*NBIN +: NBIN]),
      .rd_i      (take_s[k]),
      .full_o    (in_full_s[k]),
      .data_o    (in_data_s[k])
    );
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    assign wr_s[k]     = out_ok_s & out_en[k];
    assign drain_s[k]  = dst_valid[k] & dst_ready[k];
    assign ovf_ev_s[k] = wr_s[k] & dst_valid[k] & ~dst_ready[k];

    io_slot #(.W(NBOUT)) u_out_slot (
      .clk       (clk),
      .rst_n     (rst),
      .wr_i      (wr_s[k]),
      .wr_data_i (io_out),
      .rd_i      (drain_s[k]),
      .full_o    (dst_valid[k]),
      .data_o    (dst_data[k*NBOUT +: NBOUT])
    );
  end

  // processor read mux: only a legal strobe on a full slot returns data
  always_comb begin
    io_in = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (take_s[k]) begin
        io_in = in_data_s[k];
      end else begin
        io_in = io_in;
      end
    end
  end

  logic [NUIOIN-1:0] err_und_q, err_und_d;
  logic [NUIOOU-1:0] err_ovf_q, err_ovf_d;
  logic              err_proto_q, err_proto_d;

  // sticky flags: a same-cycle event overrides the clear
  always_comb begin
    err_und_d   = (err_clr ? '0 : err_und_q) | und_ev_s;
    err_ovf_d   = (err_clr ? '0 : err_ovf_q) | ovf_ev_s;
    err_proto_d = (err_clr ? 1'b0 : err_proto_q) | proto_ev_s;
  end

  // flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_und_q   <= '0;
      err_ovf_q   <= '0;
      err_proto_q <= 1'b0;
    end else begin
      err_und_q   <= err_und_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign err_und   = err_und_q;
  assign err_ovf   = err_ovf_q;
  assign err_proto = err_proto_q;

`ifdef IO_SCHED_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cnt_sum_t         sum_s;

  // clear first, then add every event of this cycle, saturating at the top
  always_comb begin
    sum_s = cnt_sum_t'(err_clr ? '0 : cnt_q)
          + cnt_sum_t'($countones(und_ev_s))
          + cnt_sum_t'($countones(ovf_ev_s))
          + cnt_sum_t'(proto_ev_s);
    if (sum_s > cnt_sum_t'(CNT_MAX)) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = sum_s[CNT_W-1:0];
    end
  end

  // event counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
